// File: rtl/arp_query_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : arp_query_arbiter
// Purpose  : Round-robin arbiter sharing the single ARP cache query port
//            between N_PORTS requesters. One query in flight at a time; the
//            cache response is latched and returned only to the granted port.
// Options  : ARP_ARB_TIMEOUT_EN - adds a WAIT-state watchdog that returns an
//            error response after TIMEOUT_CYCLES and absorbs the late reply.
// Revision : 1.0 - initial release
// ============================================================================
module arp_query_arbiter #(
  parameter int N_PORTS        = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_PORTS-1:0]     req_valid,
  output logic [N_PORTS-1:0]     req_ready,
  input  logic [32*N_PORTS-1:0]  req_ip,
  output logic [N_PORTS-1:0]     resp_valid,
  input  logic [N_PORTS-1:0]     resp_ready,
  output logic                   resp_error,
  output logic [47:0]            resp_mac,
  output logic                   query_request_valid,
  input  logic                   query_request_ready,
  output logic [31:0]            query_request_ip,
  input  logic                   query_response_valid,
  output logic                   query_response_ready,
  input  logic                   query_response_error,
  input  logic [47:0]            query_response_mac,
  output logic                   busy
);

  localparam int c_grant_w = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam logic [N_PORTS-1:0] c_port_one = N_PORTS'(1);

  // Out-of-range configurations are rejected at elaboration.
  if (N_PORTS < 2 || N_PORTS > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("arp_query_arbiter: N_PORTS must be 2..8 and TIMEOUT_CYCLES >= 2");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [c_grant_w-1:0]  r_grant;
  logic [c_grant_w-1:0]  r_last_grant;
  logic [31:0]           r_ip;
  logic                  r_err;
  logic [47:0]           r_mac;
  logic [c_grant_w-1:0]  w_pick;
  logic                  w_found;
  logic                  w_timeout;

`ifdef ARP_ARB_TIMEOUT_EN
  logic [31:0]           r_timer;
  logic                  r_stale;

  assign w_timeout = (r_state == S_WAIT) && !query_response_valid &&
                     (r_timer == 32'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // Round-robin search starting one past the last served port.
  always_comb begin
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = 1; k <= N_PORTS; k++) begin
      idx = (int'(r_last_grant) + k) % N_PORTS;
      if (!w_found && ((req_valid & (c_port_one << idx)) != '0)) begin
        w_found = 1'b1;
        w_pick  = c_grant_w'(idx);
      end
    end
  end

  // Next-state and handshake outputs; everything is forced low while in reset.
  always_comb begin
    w_state_nxt          = r_state;
    req_ready            = '0;
    resp_valid           = '0;
    query_request_valid  = 1'b0;
    query_response_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          req_ready[w_pick] = 1'b1;
          w_state_nxt       = S_ISSUE;
        end
`ifdef ARP_ARB_TIMEOUT_EN
        // Soak up a reply that arrives after the watchdog already fired.
        query_response_ready = r_stale;
`endif
      end
      S_ISSUE: begin
        query_request_valid = 1'b1;
        if (query_request_ready) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        query_response_ready = 1'b1;
        if (query_response_valid || w_timeout) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        resp_valid[r_grant] = 1'b1;
        if (resp_ready[r_grant]) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (rst) begin
      req_ready            = '0;
      resp_valid           = '0;
      query_request_valid  = 1'b0;
      query_response_ready = 1'b0;
    end
  end

  // State register plus grant, query IP and response capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_last_grant <= c_grant_w'(N_PORTS - 1);
      r_ip         <= '0;
      r_err        <= 1'b0;
      r_mac        <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_ip    <= req_ip[32*w_pick +: 32];
            r_grant <= w_pick;
          end
        end
        S_WAIT: begin
          if (query_response_valid) begin
            r_err <= query_response_error;
            r_mac <= query_response_mac;
          end else if (w_timeout) begin
            r_err <= 1'b1;
            r_mac <= '0;
          end
        end
        S_RESP: begin
          if (resp_ready[r_grant]) begin
            r_last_grant <= r_grant;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ARP_ARB_TIMEOUT_EN
  // Watchdog timer and stale-reply flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer <= '0;
      r_stale <= 1'b0;
    end else if (r_state == S_ISSUE) begin
      r_timer <= '0;
      r_stale <= 1'b0;
    end else if (r_state == S_WAIT) begin
      r_timer <= r_timer + 32'd1;
      if (w_timeout) begin
        r_stale <= 1'b1;
      end
    end else if (r_state == S_IDLE && r_stale && query_response_valid) begin
      r_stale <= 1'b0;
    end
  end
`endif

  assign query_request_ip = r_ip;
  assign resp_error       = r_err;
  assign resp_mac         = r_mac;
  assign busy             = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: doc/arp_query_arbiter.md
Name: arp_query_arbiter

Overview:
- Shares the single query port of the ARP cache between N independent requesters (e.g. UDP TX path, RTPS discovery, ICMP reply).
- Fair round-robin grant; one query outstanding at a time.
- Latches the cache response and returns it only to the granted requester.
- Sits between requester logic and the cache query/response channels.

Parameters:
- N_PORTS, 3, number of requesters (2..8).
- TIMEOUT_CYCLES, 1024, watchdog limit in clk cycles while waiting for a cache response; only used when ARP_ARB_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  N_PORTS  per-requester query valid.
- req_ready  out  N_PORTS  per-requester accept, one-hot or zero.
- req_ip  in  32*N_PORTS  packed query IPs; port i is [32*i+31:32*i].
- resp_valid  out  N_PORTS  per-requester response valid, one-hot or zero.
- resp_ready  in  N_PORTS  per-requester response ready.
- resp_error  out  1  latched cache error/miss flag; qualified by resp_valid.
- resp_mac  out  48  latched MAC; qualified by resp_valid.
- query_request_valid  out  1  to cache.
- query_request_ready  in  1  from cache.
- query_request_ip  out  32  to cache.
- query_response_valid  in  1  from cache.
- query_response_ready  out  1  to cache.
- query_response_error  in  1  from cache.
- query_response_mac  in  48  from cache.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst=1): state=IDLE, grant_reg=0, last_grant=N_PORTS-1 (port 0 wins first), ip_reg=0, err_reg=0, mac_reg=0, timer=0. All outputs are 0 during reset.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Combinational round-robin search starting at last_grant+1, wrapping modulo N_PORTS.
  - The first i with req_valid[i]=1 gets req_ready[i]=1 in the same cycle.
  - On that cycle: capture ip_reg=req_ip[i], grant_reg=i; next state ISSUE.
  - No valid requester: all req_ready=0; stay in IDLE.
- ISSUE:
  - query_request_valid=1, query_request_ip=ip_reg.
  - On query_request_ready=1: next state WAIT.
  - ip_reg must stay stable while valid is high.
- WAIT:
  - query_response_ready=1.
  - On query_response_valid=1: capture err_reg and mac_reg; next state RESP.
- RESP:
  - resp_valid[grant_reg]=1; resp_error=err_reg, resp_mac=mac_reg.
  - On resp_ready[grant_reg]=1: last_grant=grant_reg; next state IDLE.
  - resp_ready on other ports is ignored.
- req_ready is 0 in every state except IDLE. A requester's req_valid may drop before it is granted without any effect.
- Latency: accept at cycle T; query issued at T+1; with a cache that is always ready and answers after 1 cycle, resp_valid rises at T+3 (WAIT at T+2, RESP at T+3). The next grant is possible on the cycle after the resp handshake.
- Simultaneous requests are serialized in rotating order. Starvation bound: a waiting port is served within N_PORTS-1 other transactions.
- Requester backpressure in RESP blocks all other ports. The response held in RESP must not change.
- query_request_valid and query_response_ready are never both 1.
- Reset mid-operation: immediate return to IDLE. Any partially delivered response is dropped; the cache side must tolerate the abandoned handshake.
- grant_reg and last_grant width: clog2(N_PORTS), minimum 1 bit.

Optional Feature:
- Macro ARP_ARB_TIMEOUT_EN.
- Defined:
  - 32-bit timer clears on entering WAIT and increments each WAIT cycle.
  - When timer reaches TIMEOUT_CYCLES-1 with no query_response_valid: go to RESP with err_reg=1, mac_reg=0.
  - A late cache response is then still accepted and discarded in IDLE: query_response_ready=1 in IDLE when the flag stale_reg is set; stale_reg clears on that handshake or on the next ISSUE.
- Undefined: no timer and no stale_reg; WAIT waits indefinitely; query_response_ready=0 outside WAIT.

Test Plan:
- Port 1 alone, req_ip=0xC0A8_0102, cache returns mac 0x0200_0000_0001 error=0 one cycle later -> req_ready[1] pulses once, query_request_ip=0xC0A80102, resp_valid[1] at T+3 with that mac, error=0.
- Ports 0,1,2 all held valid from reset -> grants in order 0,1,2,0; each req_ready pulses exactly once per transaction.
- Cache returns error=1 -> resp_error=1 delivered to the granted port only; other resp_valid bits stay 0.
- Port 2 holds resp_ready=0 for 10 cycles in RESP while port 0 is valid -> resp_mac stable, req_ready[0]=0 throughout, port 0 granted on the cycle after the handshake.
- rst asserted while in WAIT -> all outputs 0 immediately; after release, port 0 is granted first.
- ARP_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, cache silent -> resp_valid with error=1, mac=0 exactly 16 cycles after entering WAIT; a cache response at cycle 20 is absorbed without producing a resp_valid.
